// File: rtl/rsa_driver.sv
// Systolic array driver: sends an init word, streams operands A and B from
// memory into the array, then writes the array results back to memory.
module rsa_driver #(
    parameter int X       = 3,
    parameter int N       = 3,
    parameter int Y       = 3,
    parameter int IN_LEN  = 8,
    parameter int OUT_LEN = 8,
    parameter int MEM_AW  = 8
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic [IN_LEN-1:0]  cfg_word,
    input  logic [MEM_AW-1:0]  a_base,
    input  logic [MEM_AW-1:0]  b_base,
    input  logic [MEM_AW-1:0]  c_base,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [MEM_AW-1:0]  mem_rd_addr,
    input  logic [IN_LEN-1:0]  mem_rd_data,
    output logic               init_val,
    output logic [IN_LEN-1:0]  init_data,
    input  logic               init_rdy,
    output logic               Xin_val,
    output logic [IN_LEN-1:0]  Xin_data,
    input  logic               Xin_rdy,
    output logic               Yin_val,
    output logic [IN_LEN-1:0]  Yin_data,
    input  logic               Yin_rdy,
    input  logic               out_val,
    input  logic [OUT_LEN-1:0] out_data,
    output logic               out_rdy,
    output logic               res_wr_en,
    output logic [MEM_AW-1:0]  res_wr_addr,
    output logic [OUT_LEN-1:0] res_wr_data
);

    localparam int XN   = X * N;
    localparam int NY   = N * Y;
    localparam int XY   = X * Y;
    localparam int LMAX = (XN > NY) ? XN : NY;
    localparam int LW   = $clog2(LMAX + 1);
    localparam int CW   = $clog2(XY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD_X,
        S_LOAD_Y,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [IN_LEN-1:0] cfg_q;
    logic [MEM_AW-1:0] a_q, b_q, c_q;
    logic [LW-1:0]     rd_cnt, xf_cnt, tot;
    logic [CW-1:0]     res_cnt;
    logic              rd_pend;
    logic [IN_LEN-1:0] fifo_q [2];
    logic              wp, rp;
    logic [1:0]        occ, lvl;
    logic              loading, fval, frdy, pop, rd_en, last_xf;
    logic              wr, last_res, accept;
    logic [MEM_AW-1:0] base, rd_addr;

    always_comb begin
        loading  = (state == S_LOAD_X) || (state == S_LOAD_Y);
        tot      = (state == S_LOAD_X) ? LW'(XN) : LW'(NY);
        base     = (state == S_LOAD_X) ? a_q : b_q;
        frdy     = (state == S_LOAD_X) ? Xin_rdy : Yin_rdy;
        fval     = loading && (occ != 2'd0);
        pop      = fval && frdy;
        // FIFO slots already claimed: stored words plus the read in flight
        lvl      = occ + {1'b0, rd_pend};
        rd_en    = loading && (rd_cnt != tot) &&
                   ((lvl < 2'd2) || ((lvl == 2'd2) && pop));
        rd_addr  = base + MEM_AW'(rd_cnt);
        last_xf  = pop && (xf_cnt == tot - LW'(1));
        accept   = (state == S_IDLE) && start;
        wr       = (state == S_COLLECT) && out_val;
        last_res = wr && (res_cnt == CW'(XY - 1));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (start) state_nx = S_INIT;
            S_INIT:    if (init_rdy) state_nx = S_LOAD_X;
            S_LOAD_X:  if (last_xf) state_nx = S_LOAD_Y;
            S_LOAD_Y:  if (last_xf) state_nx = S_COLLECT;
            S_COLLECT: if (last_res) state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            cfg_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            rd_cnt    <= '0;
            xf_cnt    <= '0;
            res_cnt   <= '0;
            rd_pend   <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            occ       <= 2'd0;
        end else begin
            state   <= state_nx;
            rd_pend <= rd_en;
            if (accept) begin
                cfg_q   <= cfg_word;
                a_q     <= a_base;
                b_q     <= b_base;
                c_q     <= c_base;
                res_cnt <= '0;
            end else if (wr) begin
                res_cnt <= res_cnt + CW'(1);
            end
            if (last_xf || accept) begin
                rd_cnt <= '0;
                xf_cnt <= '0;
            end else begin
                if (rd_en) rd_cnt <= rd_cnt + LW'(1);
                if (pop)   xf_cnt <= xf_cnt + LW'(1);
            end
            if (rd_pend) begin
                fifo_q[wp] <= mem_rd_data;
                wp         <= ~wp;
            end
            if (pop) rp <= ~rp;
            occ <= occ + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = rd_en ? rd_addr : '0;
    assign init_val    = (state == S_INIT);
    assign init_data   = init_val ? cfg_q : '0;
    assign Xin_val     = fval && (state == S_LOAD_X);
    assign Xin_data    = Xin_val ? fifo_q[rp] : '0;
    assign Yin_val     = fval && (state == S_LOAD_Y);
    assign Yin_data    = Yin_val ? fifo_q[rp] : '0;
    assign out_rdy     = (state == S_COLLECT);
    assign res_wr_en   = wr;
    assign res_wr_addr = wr ? c_q + MEM_AW'(res_cnt) : '0;
    assign res_wr_data = wr ? out_data : '0;

endmodule

// File: doc/rsa_driver.md
RSA_DRIVER -- requirements
Module: rsa_driver

Interface
REQ-001 SHALL have parameters: X, default 3, array rows; N, default 3, inner dimension; Y, default 3, array columns.
REQ-002 SHALL have parameters: IN_LEN, default 8, operand width; OUT_LEN, default 8, result width; MEM_AW, default 8, memory address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have these ports, one per line as name, direction, width, meaning:
 clk  in  1  clock
 sys_rst  in  1  async active-high reset
 start  in  1  start pulse; sampled only in IDLE
 cfg_word  in  IN_LEN  init word sent to array
 a_base, b_base, c_base  in  MEM_AW each  operand A, operand B, result base addresses; latched on accepted start
 busy  out  1  high from accepted start until done
 done  out  1  one-cycle completion pulse
 mem_rd_en  out  1  operand read strobe
 mem_rd_addr  out  MEM_AW  read address
 mem_rd_data  in  IN_LEN  read data, valid exactly 1 cycle after mem_rd_en
 init_val  out  1  init valid
 init_data  out  IN_LEN  init word
 init_rdy  in  1  init ready
 Xin_val  out  1  X stream valid
 Xin_data  out  IN_LEN  X stream data
 Xin_rdy  in  1  X stream ready
 Yin_val  out  1  Y stream valid
 Yin_data  out  IN_LEN  Y stream data
 Yin_rdy  in  1  Y stream ready
 out_val  in  1  result valid
 out_data  in  OUT_LEN  result data
 out_rdy  out  1  result ready
 res_wr_en  out  1  result write strobe
 res_wr_addr  out  MEM_AW  result write address
 res_wr_data  out  OUT_LEN  result write data

Function
REQ-005 SHALL implement states IDLE -> INIT -> LOAD_X -> LOAD_Y -> COLLECT -> DONE -> IDLE.
REQ-006 SHALL, in IDLE, accept start=1: latch cfg_word and all three base addresses, set busy=1, go to INIT; start outside IDLE SHALL be ignored.
REQ-007 SHALL, in INIT, hold init_val=1 with init_data=latched cfg_word until init_val&&init_rdy, then go to LOAD_X.
REQ-008 SHALL, in LOAD_X, read X*N words from a_base+0..a_base+X*N-1 in ascending order and present each on Xin_data; a word transfers on Xin_val&&Xin_rdy.
REQ-009 SHALL, in LOAD_Y, stream N*Y words from b_base ascending on Yin, identical in rules to LOAD_X.
REQ-010 SHALL, at each load phase, buffer read data in a 2-entry skid FIFO; a read SHALL issue only when occupancy plus in-flight reads is below 2, or equals 2 with a pop in the same cycle.
REQ-011 SHALL, with rdy held high, reach 1 word/cycle throughput; first val SHALL assert 2 cycles after phase entry.
REQ-012 SHALL hold Xin_data and Yin_data stable while val=1 and rdy=0; val SHALL never deassert without a transfer.
REQ-013 SHALL issue no read past the last address of a phase.
REQ-014 SHALL move to the next phase in the cycle after the last transfer, with the FIFO empty.
REQ-015 SHALL, in COLLECT, drive out_rdy=1 and on each out_val&&out_rdy assert res_wr_en for 1 cycle with address c_base+k and out_data, k=0..X*Y-1 in arrival order.
REQ-016 SHALL, after the X*Y-th result, enter DONE: done=1 for 1 cycle, busy=0 the cycle after, out_rdy=0 outside COLLECT.
REQ-017 SHALL compute addresses modulo 2^MEM_AW, wrapping silently.
REQ-018 SHALL size counters with $clog2(max count + 1).
REQ-019 SHALL ignore out_val outside COLLECT, with no write.
REQ-020 SHALL keep all val and rdy outputs low outside their own state.

Reset
REQ-021 SHALL, on sys_rst=1 at any time including mid-phase, immediately force state IDLE, all outputs 0, FIFO empty, and counters 0.
REQ-022 SHALL discard the pending memory read on reset, and SHALL need a new start after reset is released.

Verification
REQ-023 SHALL cover: defaults, memory A=1..9, B=11..19, rdy high always -> Xin sequence 1..9 on 9 consecutive cycles, Yin 11..19 consecutive, init_data=cfg_word.
REQ-024 SHALL cover: Xin_rdy toggling 1,0,0,1,... -> no word lost or duplicated, Xin_data stable while stalled, exactly 9 mem reads.
REQ-025 SHALL cover: 9 results 100..108 with gaps, c_base=0x20 -> writes 0x20..0x28 with 100..108, done exactly once, busy drop next cycle.
REQ-026 SHALL cover: start asserted during LOAD_Y -> no effect; wrap case a_base=0xFC -> reads FC,FD,FE,FF,00..04.
REQ-027 SHALL cover: sys_rst pulse after 4 Xin transfers -> all outputs 0 same cycle; new start -> full correct run from a_base.
REQ-028 SHALL cover: init_rdy held low 5 cycles -> init_val stays high, no mem_rd_en until handshake.
